// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
//   op_e    : opcode carried on i_op (SUB, CMP, CLRBIT, CONV)
//   state_e : sequencer FSM states
//   ST_*    : bit positions within the 4-bit unit status word
package alu_seq_pkg;

  typedef enum logic [1:0] {
    SUB    = 2'd0,
    CMP    = 2'd1,
    CLRBIT = 2'd2,
    CONV   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ST_W    = 4;
  localparam int unsigned ST_ERR  = 0;
  localparam int unsigned ST_NEG  = 1;
  localparam int unsigned ST_PAR  = 2;
  localparam int unsigned ST_ONES = 3;

endpackage

// File: rtl/alu_op_sequencer_units.sv
// Combinational sign-magnitude units and the opcode-driven result mux.
//   mod1 : A - B (error on magnitude overflow)
//   mod2 : A < B (result 1 or 0)
//   mod3 : clear bit B of A (error when B is negative or >= m)
//   mod4 : sign-magnitude A to two's complement (error on negative zero)
//   alu_unit_mux : op, a, b -> result, status of the selected unit
// Every unit drives a zero result on error; status is computed on the
// driven result.

module mod1
  import alu_seq_pkg::*;
#(
  parameter int unsigned m = 4,
  parameter int unsigned n = 2
) (
  input  logic [m-1:0]    a,
  input  logic [m-1:0]    b,
  output logic [m-1:0]    result,
  output logic [ST_W-1:0] status
);
  // n is part of the shared unit interface only
  if (n == 0) begin : g_n_unused
  end

  logic signed [m:0] sa, sb, diff;
  logic [m:0]        mag;
  logic              err;

  always_comb begin
    sa   = a[m-1] ? -$signed({2'b00, a[m-2:0]}) : $signed({2'b00, a[m-2:0]});
    sb   = b[m-1] ? -$signed({2'b00, b[m-2:0]}) : $signed({2'b00, b[m-2:0]});
    diff = sa - sb;
    mag  = diff[m] ? $unsigned(-diff) : $unsigned(diff);
    err  = mag[m] | mag[m-1];
    result = err ? '0 : {diff[m], mag[m-2:0]};
    status          = '0;
    status[ST_ERR]  = err;
    status[ST_NEG]  = result[m-1];
    status[ST_PAR]  = ~^result;
    status[ST_ONES] = &result;
  end
endmodule

module mod2
  import alu_seq_pkg::*;
#(
  parameter int unsigned m = 4,
  parameter int unsigned n = 2
) (
  input  logic [m-1:0]    a,
  input  logic [m-1:0]    b,
  output logic [m-1:0]    result,
  output logic [ST_W-1:0] status
);
  if (n == 0) begin : g_n_unused
  end

  logic signed [m:0] sa, sb;

  always_comb begin
    sa     = a[m-1] ? -$signed({2'b00, a[m-2:0]}) : $signed({2'b00, a[m-2:0]});
    sb     = b[m-1] ? -$signed({2'b00, b[m-2:0]}) : $signed({2'b00, b[m-2:0]});
    result = {{(m-1){1'b0}}, (sa < sb)};
    status          = '0;
    status[ST_NEG]  = result[m-1];
    status[ST_PAR]  = ~^result;
    status[ST_ONES] = &result;
  end
endmodule

module mod3
  import alu_seq_pkg::*;
#(
  parameter int unsigned m = 4,
  parameter int unsigned n = 2
) (
  input  logic [m-1:0]    a,
  input  logic [m-1:0]    b,
  output logic [m-1:0]    result,
  output logic [ST_W-1:0] status
);
  if (n == 0) begin : g_n_unused
  end

  int unsigned  idx;
  logic         err;
  logic [m-1:0] raw;

  always_comb begin
    idx = 32'(b[m-2:0]);
    err = b[m-1] || (idx >= m);
    raw = a;
    for (int unsigned i = 0; i < m; i++) begin
      raw[i] = a[i] & (i != idx);
    end
    result = err ? '0 : raw;
    status          = '0;
    status[ST_ERR]  = err;
    status[ST_NEG]  = result[m-1];
    status[ST_PAR]  = ~^result;
    status[ST_ONES] = &result;
  end
endmodule

module mod4
  import alu_seq_pkg::*;
#(
  parameter int unsigned m = 4,
  parameter int unsigned n = 2
) (
  input  logic [m-1:0]    a,
  output logic [m-1:0]    result,
  output logic [ST_W-1:0] status
);
  if (n == 0) begin : g_n_unused
  end

  logic err;

  always_comb begin
    err    = a[m-1] && (a[m-2:0] == '0);
    result = err ? '0 : (a[m-1] ? -{1'b0, a[m-2:0]} : a);
    status          = '0;
    status[ST_ERR]  = err;
    status[ST_NEG]  = result[m-1];
    status[ST_PAR]  = ~^result;
    status[ST_ONES] = &result;
  end
endmodule

module alu_unit_mux
  import alu_seq_pkg::*;
#(
  parameter int unsigned m = 4,
  parameter int unsigned n = 2
) (
  input  op_e             op,
  input  logic [m-1:0]    a,
  input  logic [m-1:0]    b,
  output logic [m-1:0]    result,
  output logic [ST_W-1:0] status
);
  logic [m-1:0]    r_sub, r_cmp, r_clr, r_conv;
  logic [ST_W-1:0] s_sub, s_cmp, s_clr, s_conv;

  mod1 #(.m(m), .n(n)) u_sub  (.a(a), .b(b), .result(r_sub),  .status(s_sub));
  mod2 #(.m(m), .n(n)) u_cmp  (.a(a), .b(b), .result(r_cmp),  .status(s_cmp));
  mod3 #(.m(m), .n(n)) u_clr  (.a(a), .b(b), .result(r_clr),  .status(s_clr));
  mod4 #(.m(m), .n(n)) u_conv (.a(a),        .result(r_conv), .status(s_conv));

  always_comb begin
    result = '0;
    status = '0;
    case (op)
      SUB:    begin result = r_sub;  status = s_sub;  end
      CMP:    begin result = r_cmp;  status = s_cmp;  end
      CLRBIT: begin result = r_clr;  status = s_clr;  end
      CONV:   begin result = r_conv; status = s_conv; end
      default: ;
    endcase
    // a failing unit's result never leaves the mux
    if (status[ST_ERR]) result = '0;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer for the four sign-magnitude units: accepts one command over
// valid/ready, executes it for one cycle, holds the result until acked.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_valid / o_ready    : command handshake (i_op, i_chain, i_argA, i_argB)
//   i_clear              : clears held result and error counter
//   o_valid / i_ack      : result handshake (o_result, o_status)
//   o_err_cnt            : saturating count of completed commands in error
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned m     = 4,
  parameter int unsigned n     = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic             i_chain,
  input  logic [m-1:0]     i_argA,
  input  logic [m-1:0]     i_argB,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [m-1:0]     o_result,
  output logic [ST_W-1:0]  o_status,
  output logic [ERR_W-1:0] o_err_cnt
);

  state_e          state, state_nx;
  op_e             op_q;
  logic [m-1:0]    a_q, b_q, held, a_eff;
  logic [m-1:0]    unit_result;
  logic [ST_W-1:0] unit_status;
  logic            accept, capture;

  alu_unit_mux #(.m(m), .n(n)) u_mux (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (unit_result),
    .status (unit_status)
  );

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nx = EXEC;
      end
      EXEC: state_nx = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept  = (state == IDLE) && i_valid;
  assign capture = (state == EXEC);
  // a same-cycle clear is visible to the chained read
  assign a_eff   = !i_chain ? i_argA : (i_clear ? '0 : held);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q      <= SUB;
      a_q       <= '0;
      b_q       <= '0;
      held      <= '0;
      o_result  <= '0;
      o_status  <= '0;
      o_err_cnt <= '0;
    end else begin
      if (accept) begin
        op_q <= op_e'(i_op);
        a_q  <= a_eff;
        b_q  <= i_argB;
      end
      // capture outranks clear for the held register
      if (capture) begin
        o_result <= unit_result;
        o_status <= unit_status;
        held     <= unit_result;
      end else if (i_clear) begin
        held <= '0;
      end
      if (i_clear) begin
        o_err_cnt <= '0;
      end else if (capture && unit_status[ST_ERR] && (o_err_cnt != '1)) begin
        o_err_cnt <= o_err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int unsigned M     = 4;
  localparam int unsigned ERR_W = 8;

  logic             i_clk   = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [1:0]       i_op    = 2'd0;
  logic             i_chain = 1'b0;
  logic [M-1:0]     i_argA  = '0;
  logic [M-1:0]     i_argB  = '0;
  logic             i_clear = 1'b0;
  logic             o_valid;
  logic             i_ack;
  logic [M-1:0]     o_result;
  logic [3:0]       o_status;
  logic [ERR_W-1:0] o_err_cnt;

  logic auto_ack = 1'b0;
  logic ack_man  = 1'b0;
  logic rnd_ack  = 1'b0;
  assign i_ack = auto_ack ? rnd_ack : ack_man;

  alu_op_sequencer #(.m(M), .n(2), .ERR_W(ERR_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_op      (i_op),
    .i_chain   (i_chain),
    .i_argA    (i_argA),
    .i_argB    (i_argB),
    .i_clear   (i_clear),
    .o_valid   (o_valid),
    .i_ack     (i_ack),
    .o_result  (o_result),
    .o_status  (o_status),
    .o_err_cnt (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] res;
    logic [3:0] st;
    logic [7:0] err;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int          exp_err = 0;
  logic [3:0]  exp_held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference: operands interpreted as signed integers from sign-magnitude.
  function automatic int sm2i(input logic [3:0] x);
    return x[3] ? -int'({1'b0, x[2:0]}) : int'({1'b0, x[2:0]});
  endfunction

  function automatic void model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] r, output logic [3:0] st);
    int   ia, ib, d;
    logic err;
    ia  = sm2i(a);
    ib  = sm2i(b);
    err = 1'b0;
    r   = 4'd0;
    case (op)
      2'd0: begin
        d = ia - ib;
        if (d > 7 || d < -7) err = 1'b1;
        else r = (d < 0) ? {1'b1, 3'(-d)} : 4'(d);
      end
      2'd1: r = (ia < ib) ? 4'd1 : 4'd0;
      2'd2: begin
        if (b[3] || b[2:0] > 3'd3) err = 1'b1;
        else begin
          r = a;
          r[b[1:0]] = 1'b0;
        end
      end
      default: begin
        if (a == 4'b1000) err = 1'b1;
        else r = 4'(ia);
      end
    endcase
    st = {(r == 4'hf), ($countones(r) % 2 == 0), r[3], err};
  endfunction

  initial begin
    forever begin
      @(negedge i_clk);
      rnd_ack = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops one expectation per o_valid rise, then checks it stays stable.
  exp_t cur;
  logic have_cur = 1'b0;
  logic prev_v   = 1'b0;
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_valid) begin
        if (!prev_v) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            have_cur = 1'b0;
            $display("FAIL unexpected_valid: got result 0x%0h, required no pending result", o_result);
          end else begin
            cur = q.pop_front();
            have_cur = 1'b1;
            chk("result", 32'(o_result), 32'(cur.res));
            chk("status", 32'(o_status), 32'(cur.st));
            chk("err_cnt", 32'(o_err_cnt), 32'(cur.err));
          end
        end else if (have_cur) begin
          chk("result_stable", 32'(o_result), 32'(cur.res));
          chk("status_stable", 32'(o_status), 32'(cur.st));
        end
      end
      prev_v = i_rst_n && o_valid;
    end
  end

  task automatic wait_ready();
    int unsigned w = 0;
    while (!o_ready && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    if (!o_ready) timeout("wait_ready");
  endtask

  task automatic issue(input logic [1:0] op, input logic chain, input logic [3:0] a,
                       input logic [3:0] b, input logic clr_acc, input logic clr_exec,
                       input logic keep_v);
    exp_t       e;
    logic [3:0] aeff;
    wait_ready();
    if (!o_ready) return;
    i_valid = 1'b1;
    i_op    = op;
    i_chain = chain;
    i_argA  = a;
    i_argB  = b;
    i_clear = clr_acc;
    if (clr_acc) begin
      exp_err  = 0;
      exp_held = 4'd0;
    end
    aeff = chain ? exp_held : a;
    model(op, aeff, b, e.res, e.st);
    if (clr_exec) exp_err = 0;
    else if (e.st[0] && exp_err < 255) exp_err++;
    exp_held = e.res;
    e.err = 8'(exp_err);
    q.push_back(e);
    @(negedge i_clk);
    i_valid = keep_v;
    i_clear = clr_exec;
    i_argA  = 4'($urandom);
    i_argB  = 4'($urandom);
    chk("exec_ready", 32'(o_ready), 0);
    chk("exec_valid", 32'(o_valid), 0);
    @(negedge i_clk);
    i_clear = 1'b0;
    chk("latency_valid", 32'(o_valid), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_result", 32'(o_result), 0);
    chk("rst_status", 32'(o_status), 0);
    chk("rst_err", 32'(o_err_cnt), 0);

    // SUB held until ack
    issue(2'd0, 1'b0, 4'b0101, 4'b0011, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge i_clk);
    chk("hold_valid", 32'(o_valid), 1);
    ack_man = 1'b1;
    @(negedge i_clk);
    ack_man = 1'b0;
    chk("ready_after_ack", 32'(o_ready), 1);
    chk("valid_after_ack", 32'(o_valid), 0);
    auto_ack = 1'b1;

    issue(2'd1, 1'b1, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0);
    issue(2'd2, 1'b0, 4'b1111, 4'b0010, 1'b0, 1'b0, 1'b0);
    issue(2'd2, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    issue(2'd3, 1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0);
    issue(2'd3, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    // clear during EXEC: counter cleared, held still captures 0100
    issue(2'd0, 1'b0, 4'b0101, 4'b0001, 1'b0, 1'b1, 1'b0);
    issue(2'd0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    // clear at a chained accept: A_eff is 0
    issue(2'd1, 1'b1, 4'b0111, 4'b0001, 1'b1, 1'b0, 1'b0);
    issue(2'd3, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    // clear coinciding with an error completion
    issue(2'd3, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0);

    // i_valid held high through DONE
    wait_ready();
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    issue(2'd0, 1'b0, 4'b0011, 4'b1010, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("no_second_accept", 32'(o_ready), 0);
    end
    ack_man = 1'b1;
    @(negedge i_clk);
    ack_man = 1'b0;
    i_valid = 1'b0;
    chk("ready_after_held_valid", 32'(o_ready), 1);
    auto_ack = 1'b1;

    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 1'b0);
    end

    for (int i = 0; i < 256; i++) begin
      issue(2'd3, 1'b0, 4'b1000, 4'($urandom), 1'b0, 1'b0, 1'b0);
    end
    wait_ready();
    chk("err_saturated", 32'(o_err_cnt), 255);

    // reset during EXEC
    issue(2'd0, 1'b0, 4'b0101, 4'b0011, 1'b0, 1'b0, 1'b0);
    wait_ready();
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    i_valid  = 1'b1;
    i_op     = 2'd0;
    i_chain  = 1'b0;
    i_argA   = 4'b0111;
    i_argB   = 4'b0001;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("pre_reset_exec", 32'(o_ready), 0);
    #1 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(o_ready), 1);
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_result", 32'(o_result), 0);
    chk("mid_rst_status", 32'(o_status), 0);
    chk("mid_rst_err", 32'(o_err_cnt), 0);
    @(negedge i_clk);
    i_rst_n  = 1'b1;
    exp_err  = 0;
    exp_held = 4'd0;
    @(negedge i_clk);
    chk("post_rst_ready", 32'(o_ready), 1);
    chk("post_rst_valid", 32'(o_valid), 0);
    auto_ack = 1'b1;
    // held register was reset: chained A is 0
    issue(2'd1, 1'b1, 4'b0110, 4'b0001, 1'b0, 1'b0, 1'b0);

    wait_ready();
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
